// File: rtl/ifft_pkg.sv
// rtl/ifft_pkg.sv - shared states, twiddles and transform size for the 4-point inverse FFT
package ifft_pkg;

  localparam int N = 4;

  // Inverse twiddles as packed {real, imag}, Q1.7 per component
  localparam logic [15:0] TW_W0 = 16'h7F00;
  localparam logic [15:0] TW_WJ = 16'h007F;

  typedef enum logic [1:0] {
    IDLE,
    STAGE1,
    STAGE2,
    DONE
  } state_t;

endpackage

// File: rtl/ifft4_butterfly.sv
// rtl/ifft4_butterfly.sv - radix-2 complex butterfly: plus = a + w*b, minus = a - w*b, wrapping per component
module ifft4_butterfly #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  output logic [WIDTH-1:0] plus,
  output logic [WIDTH-1:0] minus
);

  localparam int H = WIDTH / 2;

  // Components are widened so the products and their sum never overflow
  logic signed [2*H:0] ar, ai, br, bi, wr, wi;
  logic signed [2*H:0] pr, pi;
  logic signed [2*H:0] tr, ti;

  function automatic logic [2*H:0] sext(input logic [H-1:0] v);
    return {{(H+1){v[H-1]}}, v};
  endfunction

  // Complex multiply, truncating shift back to Q1.(H-1), then add/subtract modulo 2^H
  always_comb begin
    ar = sext(a[WIDTH-1:H]);
    ai = sext(a[H-1:0]);
    br = sext(b[WIDTH-1:H]);
    bi = sext(b[H-1:0]);
    wr = sext(w[WIDTH-1:H]);
    wi = sext(w[H-1:0]);
    pr = wr * br - wi * bi;
    pi = wr * bi + wi * br;
    tr = pr >>> (H - 1);
    ti = pi >>> (H - 1);
    plus  = {H'(ar + tr), H'(ai + ti)};
    minus = {H'(ar - tr), H'(ai - ti)};
  end

endmodule

// File: rtl/ifft4.sv
// rtl/ifft4.sv - 4-point inverse FFT, two butterfly stages, 3-cycle latency; IFFT4_SCALE_EN enables 1/N output scaling
module ifft4
  import ifft_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*WIDTH-1:0] in,
  output logic [N*WIDTH-1:0] out,
  output logic               done
);

  localparam int H = WIDTH / 2;

  state_t state, state_nxt;
  logic capture;

  // Operands: X[0..3] after capture, then {p1, m1, p2, m2} after STAGE1
  logic [WIDTH-1:0] d [N];
  logic [N*WIDTH-1:0] out_q;

  logic [WIDTH-1:0] tw_w0, tw_b;
  logic [WIDTH-1:0] bf1_plus, bf1_minus, bf2_plus, bf2_minus;

  assign tw_w0 = WIDTH'(TW_W0);
  assign tw_b  = (state == STAGE2) ? WIDTH'(TW_WJ) : WIDTH'(TW_W0);

  ifft4_butterfly #(.WIDTH(WIDTH)) u_bf1 (
    .a     (d[0]),
    .b     (d[2]),
    .w     (tw_w0),
    .plus  (bf1_plus),
    .minus (bf1_minus)
  );

  ifft4_butterfly #(.WIDTH(WIDTH)) u_bf2 (
    .a     (d[1]),
    .b     (d[3]),
    .w     (tw_b),
    .plus  (bf2_plus),
    .minus (bf2_minus)
  );

`ifdef IFFT4_SCALE_EN
  function automatic logic [WIDTH-1:0] post(input logic [WIDTH-1:0] s);
    logic signed [H-1:0] re, im;
    re = s[WIDTH-1:H];
    im = s[H-1:0];
    return {re >>> 2, im >>> 2};
  endfunction
`else
  function automatic logic [WIDTH-1:0] post(input logic [WIDTH-1:0] s);
    return s;
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, capture strobe and gated outputs
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    done      = 1'b0;
    out       = '0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = STAGE1;
        end
      end
      STAGE1: state_nxt = STAGE2;
      STAGE2: state_nxt = DONE;
      DONE: begin
        done = 1'b1;
        out  = out_q;
        if (start) begin
          capture   = 1'b1;
          state_nxt = STAGE1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand registers: load inputs on capture, first-stage results after STAGE1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < N; k++) d[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N; k++) d[k] <= in[k*WIDTH +: WIDTH];
    end else if (state == STAGE1) begin
      d[0] <= bf1_plus;
      d[1] <= bf1_minus;
      d[2] <= bf2_plus;
      d[3] <= bf2_minus;
    end
  end

  // Result register in output order bf1+, bf2+, bf1-, bf2-
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                out_q <= '0;
    else if (state == STAGE2)  out_q <= {post(bf2_minus), post(bf1_minus), post(bf2_plus), post(bf1_plus)};
  end

endmodule

// File: tb/tb_ifft4.sv
// tb/tb_ifft4.sv - self-checking bench for ifft4 against a behavioural 4-point IFFT model
module tb_ifft4;

  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [63:0] in_v = '0;
  logic [63:0] out_v;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  int          since_cap = -1;
  logic [63:0] cap_v = '0;
  logic [63:0] exp_res = '0;

  localparam logic [63:0] V026 = {16'h0000, 16'h0000, 16'h0000, 16'h0400};
  localparam logic [63:0] V027 = {16'h0000, 16'h0000, 16'h0400, 16'h0000};
  localparam logic [63:0] VX2  = {16'h0000, 16'h0400, 16'h0000, 16'h0000};
`ifdef IFFT4_SCALE_EN
  localparam logic [63:0] E026 = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
  localparam logic [63:0] E027 = {16'h00FF, 16'hFF00, 16'h0000, 16'h0000};
  localparam logic [63:0] EX2  = {16'hFF00, 16'h0000, 16'hFF00, 16'h0000};
`else
  localparam logic [63:0] E026 = {16'h0400, 16'h0400, 16'h0400, 16'h0400};
  localparam logic [63:0] E027 = {16'h00FD, 16'hFD00, 16'h0003, 16'h0300};
  localparam logic [63:0] EX2  = {16'hFD00, 16'h0300, 16'hFD00, 16'h0300};
`endif

  ifft4 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in_v),
    .out   (out_v),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wrap8(input int v);
    logic [7:0] b;
    b = v[7:0];
    return int'($signed(b));
  endfunction

  function automatic int comp(input logic [63:0] v, input int k, input bit im);
    logic [7:0] b;
    b = im ? v[k*16 +: 8] : v[k*16+8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic void bfly(input int ar, input int ai, input int br, input int bi,
                               input int wr, input int wi,
                               output int pr, output int pi, output int mr, output int mi);
    int tr, ti;
    tr = (wr * br - wi * bi) >>> 7;
    ti = (wr * bi + wi * br) >>> 7;
    pr = wrap8(ar + tr);
    pi = wrap8(ai + ti);
    mr = wrap8(ar - tr);
    mi = wrap8(ai - ti);
  endfunction

  // Radix-2 DIT inverse transform of X[0..3] with twiddles 127/128 and +j*127/128
  function automatic logic [63:0] ifft_model(input logic [63:0] x);
    int xr[4], xi[4], yr[4], yi[4];
    int p1r, p1i, m1r, m1i, p2r, p2i, m2r, m2i;
    int tr, ti;
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      xr[k] = comp(x, k, 1'b0);
      xi[k] = comp(x, k, 1'b1);
    end
    bfly(xr[0], xi[0], xr[2], xi[2], 127, 0, p1r, p1i, m1r, m1i);
    bfly(xr[1], xi[1], xr[3], xi[3], 127, 0, p2r, p2i, m2r, m2i);
    bfly(p1r, p1i, p2r, p2i, 127, 0, yr[0], yi[0], yr[2], yi[2]);
    bfly(m1r, m1i, m2r, m2i, 0, 127, yr[1], yi[1], yr[3], yi[3]);
    for (int k = 0; k < 4; k++) begin
      tr = yr[k];
      ti = yi[k];
`ifdef IFFT4_SCALE_EN
      tr = tr >>> 2;
      ti = ti >>> 2;
`endif
      r[k*16+8 +: 8] = tr[7:0];
      r[k*16 +: 8]   = ti[7:0];
    end
    return r;
  endfunction

  // Reference timeline: capture accepted only when not busy, result two edges later
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      since_cap = -1;
    end else if (start && (since_cap < 0 || since_cap >= 2)) begin
      since_cap = 0;
      cap_v = in_v;
    end else if (since_cap >= 0 && since_cap < 2) begin
      since_cap = since_cap + 1;
      if (since_cap == 2) exp_res = ifft_model(cap_v);
    end
  end

  // Every-cycle comparison of done and out against the reference
  always @(negedge clk) begin
    logic ed;
    logic [63:0] eo;
    ed = (since_cap == 2);
    eo = ed ? exp_res : 64'h0;
    check("cyc_done", 64'(done), 64'(ed));
    check("cyc_out", out_v, eo);
  end

  // Pulse start with vector x, scramble in[] afterwards, count negedges until done
  task automatic run_one(input logic [63:0] x, output int lat);
    in_v  = x;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_v  = {$urandom, $urandom};
    lat = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [3:0] pat;

    repeat (3) @(negedge clk);
    check("reset_done", 64'(done), 64'h0);
    check("reset_out", out_v, 64'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", 64'(done), 64'h0);

    check("model_026", ifft_model(V026), E026);
    check("model_027", ifft_model(V027), E027);
    check("model_x2", ifft_model(VX2), EX2);

    run_one(V026, lat);
    check("lat_026", 64'(lat), 64'd3);
    check("out_026", out_v, E026);

    run_one(V027, lat);
    check("lat_027", 64'(lat), 64'd3);
    check("out_027", out_v, E027);

    repeat (20) @(negedge clk);
    check("hold_out", out_v, E027);
    check("hold_done", 64'(done), 64'h1);

    run_one(VX2, lat);
    check("out_x2", out_v, EX2);

    // Back-to-back restart from DONE with start held and in[] churning
    pat[3] = done;
    start = 1'b1;
    in_v = V026;
    @(negedge clk);
    pat[2] = done;
    in_v = {$urandom, $urandom};
    @(negedge clk);
    pat[1] = done;
    in_v = {$urandom, $urandom};
    @(negedge clk);
    pat[0] = done;
    check("b2b_pattern", 64'(pat), 64'b1001);
    check("b2b_out", out_v, E026);
    for (int i = 0; i < 9; i++) begin
      in_v = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // start reasserted during STAGE1 must not disturb latency or result
    in_v = V027;
    start = 1'b1;
    @(negedge clk);
    in_v = V026;
    @(negedge clk);
    start = 1'b0;
    in_v = {$urandom, $urandom};
    @(negedge clk);
    check("s1_done", 64'(done), 64'h1);
    check("s1_out", out_v, E027);

    // Extremes and random vectors go through the cycle checker
    run_one({16'h807F, 16'h7F80, 16'h8080, 16'h7F7F}, lat);
    run_one({16'h8000, 16'h8000, 16'h8000, 16'h8000}, lat);
    run_one({16'h7F7F, 16'h7F7F, 16'h7F7F, 16'h7F7F}, lat);
    for (int i = 0; i < 6; i++) begin
      run_one({$urandom, $urandom}, lat);
      check("lat_rand", 64'(lat), 64'd3);
    end

    // Reset while DONE: outputs clear without waiting for a clock edge
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_done_done", 64'(done), 64'h0);
    check("rst_done_out", out_v, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset mid-STAGE2
    in_v = V027;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_s2_done", 64'(done), 64'h0);
    check("rst_s2_out", out_v, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 64'(done), 64'h0);

    run_one(V026, lat);
    check("post_rst_lat", 64'(lat), 64'd3);
    check("post_rst_out", out_v, E026);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifft4.md
IFFT4 -- requirements
Module: ifft4

Interface
REQ-001 Parameter: WIDTH, 16, width of one packed complex sample; real part in bits [WIDTH-1:WIDTH/2], imaginary part in bits [WIDTH/2-1:0], each two's complement Q1.(WIDTH/2-1).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin a transform on the current in[] values.
REQ-005 Port: in  input  4 x WIDTH  frequency-domain samples X[0..3], signed.
REQ-006 Port: out  output  4 x WIDTH  time-domain samples x[0..3], signed.
REQ-007 Port: done  output  1  result valid on out[].

Function
REQ-008 States SHALL be: IDLE, STAGE1, STAGE2, DONE.
REQ-009 IDLE with start=1 at an edge SHALL capture in[0..3] and go to STAGE1; start=0 SHALL remain in IDLE.
REQ-010 STAGE1 SHALL compute butterflies (X0,X2,W0) and (X1,X3,W0); the next edge SHALL register results and go to STAGE2 unconditionally.
REQ-011 STAGE2 SHALL compute (p1,p2,W0) and (m1,m2,W+1), where p/m are STAGE1 plus/minus outputs of butterfly 1/2; the next edge SHALL register out[] and go to DONE.
REQ-012 Inverse twiddles SHALL be W0 = real 0x7F, imag 0x00 and W+1 (+j) = real 0x00, imag 0x7F.
REQ-013 Output order SHALL be out[0]=bf1 plus, out[1]=bf2 plus, out[2]=bf1 minus, out[3]=bf2 minus.
REQ-014 Butterfly arithmetic SHALL be: t = w*b with each component product summed, then arithmetic-shifted right by WIDTH/2-1 (truncate); plus = a+t, minus = a-t; each component wraps modulo 2^(WIDTH/2).
REQ-015 done SHALL be 1 exactly while in DONE; out[] SHALL be all-zero in every other state.
REQ-016 done SHALL rise two edges after the capture edge, i.e. 3 cycles of latency counting the capture edge.
REQ-017 DONE with start=1 SHALL recapture in[] and go to STAGE1, so done drops for two cycles; DONE with start=0 SHALL hold out[] and done.
REQ-018 start SHALL be ignored in STAGE1 and STAGE2; in[] changes after the capture edge SHALL NOT affect the result.

Reset
REQ-019 Reset low SHALL immediately force IDLE, done=0, out[]=0 and all operand registers to 0, including mid-transform.
REQ-020 After reset release, the first start SHALL behave per REQ-009; no partial result SHALL appear.

Configuration
REQ-021 Macro IFFT4_SCALE_EN defined: each output component SHALL be arithmetic-shifted right by 2 (1/N normalisation, round toward -inf) before registering in out[].
REQ-022 Macro undefined: out[] SHALL be the unscaled STAGE2 results; latency SHALL be identical in both builds.

Structure
REQ-023 Package ifft_pkg SHALL hold the state enum typedef, the W0/W+1 twiddle constants and the N=4 constant.
REQ-024 The datapath SHALL instantiate the existing butterfly sub-module twice, with operands and twiddles muxed by state; no other sub-modules.

Verification
REQ-025 Reset low mid-STAGE2 -> done=0 and out[]=0 the same cycle; IDLE after release.
REQ-026 in={0x0400,0,0,0}, start pulse -> done two edges after capture; out all 0x0400 (unscaled) / all 0x0100 (IFFT4_SCALE_EN).
REQ-027 in={0,0x0400,0,0} -> out={0x0300,0x0003,0xFD00,0x00FD} unscaled; {0x0000,0x0000,0xFF00,0x00FF} scaled.
REQ-028 start held high, in[] changed every cycle -> result reflects only the capture-edge values; done pattern 1,0,0,1 across a back-to-back restart from DONE.
REQ-029 start=0 in DONE for 20 cycles -> out[] and done stable; start=1 in STAGE1 -> no effect on latency or result.
